float_divider: RTL and testbench
================================

// Module: float_divider
// PURPOSE
//  Iterative IEEE-754 single-precision divider, z = a / b: the inverse of the
//  pipelined FP32 multiplier, sharing its operand/result format and clk/clrn/enable.
//  Radix-2 restoring mantissa division, one quotient bit per cycle, round-to-nearest-even.
//  Start/valid handshake; one operation in flight. Sits beside the multiplier in the FPU datapath.
// PARAMETERS
//  QBITS   26   quotient bits generated (24 mantissa + 1 normalise + 1 guard); fixed at 26
// PORTS
//  clk       in   1   clock, rising edge
//  clrn      in   1   asynchronous active-low reset
//  enable    in   1   global advance; 0 freezes every register
//  start     in   1   launch a division; sampled only in IDLE with enable=1
//  input_a   in   32  dividend, FP32
//  input_b   in   32  divisor, FP32
//  busy      out  1   high in every state except IDLE
//  valid     out  1   one-cycle result strobe (high in DONE)
//  output_z  out  32  quotient, FP32; registered, held until the next result
//  exception out  1   error flag, qualified by valid (see CONFIGURATION)
// BEHAVIOUR
//  Reset (clrn=0, any time, including mid-division): state IDLE; busy=0, valid=0,
//   output_z=0, exception=0; in-flight operation discarded.
//  enable=0: all state, counters and outputs hold; start ignored.
//  FSM: IDLE -start-> DIVIDE (normal operands) | DONE (special operands);
//   DIVIDE (26 cycles, counter 25..0) -> ROUND -> DONE -> IDLE.
//   start while busy is ignored; no queueing.
//  Latency: start at edge 0 -> valid high after edge 28 (normal), after edge 1 (special).
//   Back-to-back: next start is accepted in the IDLE cycle after DONE.
//  Subnormals flushed: exp==0 operand is signed zero; underflowing result is signed zero.
//  Specials, priority order (sign = sa^sb except NaN):
//   any NaN, 0/0, inf/inf -> 0x7FC00000, invalid;  finite/0 -> signed inf, div-by-zero;
//   inf/finite -> signed inf;  0/nonzero, finite/inf -> signed zero.
//  Normal path: ma={1,fa}, mb={1,fb} (24b); 25-bit remainder r=ma; each cycle
//   q=(r>=mb), r=(q ? r-mb : r)<<1. Exponent e = ea - eb + 127, 10-bit signed.
//   q[25]=0 -> shift quotient left 1, e-=1. Guard = next bit; sticky = (r!=0).
//   RNE: increment when guard & (sticky | lsb); mantissa carry-out -> e+=1.
//   e>=255 -> signed inf, overflow;  e<=0 -> signed zero.
// CONFIGURATION
//  FDIV_EXCEPTION_EN defined: exception is registered with output_z and set on
//   invalid, div-by-zero or overflow; cleared by the next result or by reset.
//  Not defined: exception tied to 0, no flag logic synthesised; output_z unchanged.
// STRUCTURE
//  Shared package fp32_pkg: EXP_BIAS=127, FP32_QNAN=32'h7FC00000, FP32_INF field values,
//   field widths (1/8/23), and the FSM state enum {IDLE, DIVIDE, ROUND, DONE}.
//  One combinational sub-module: fdiv_round_pack (normalise, RNE, overflow/underflow,
//   pack) taking sign, 10-bit exponent, 26-bit quotient and sticky.
// TESTING
//  0x40C00000 / 0x40000000 (6/2) -> output_z=0x40400000, valid 28 cycles after start, exception=0.
//  0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (round-up via guard+sticky).
//  0x3F800000 / 0x00000000 -> 0x7F800000 one cycle after start; exception=1 when enabled.
//  0x00000000 / 0x00000000 -> 0x7FC00000; 0x7F000000 / 0x3E800000 -> 0x7F800000 overflow.
//  Stall/abort: enable=0 for 5 cycles mid-DIVIDE -> valid 33 cycles after start;
//   start while busy ignored; clrn low mid-DIVIDE -> busy=0, output_z=0, no valid.

Source files
------------

// File: rtl/fp32_pkg.sv
// ---------------------------------------------------------------------------
// fp32_pkg
// Shared FP32 definitions for the FPU datapath (multiplier and divider).
// Contents:
//   field widths (sign/exponent/fraction), exponent bias, canonical quiet NaN,
//   infinity field values, packed operand struct, divider FSM state enum,
//   and a small helper that packs sign/exponent/fraction into a word.
// No ports; imported with `import fp32_pkg::*;`.
// ---------------------------------------------------------------------------
package fp32_pkg;

  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;

  // Quotient bits produced by the divider: 24 mantissa + 1 normalise + 1 guard.
  localparam int QBITS    = 26;

  localparam logic [31:0]       FP32_QNAN     = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0]  FP32_INF_EXP  = 8'hFF;
  localparam logic [FRAC_W-1:0] FP32_INF_FRAC = 23'h0;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    ROUND,
    DONE
  } fdiv_state_t;

  function automatic logic [31:0] fp32_pack(input logic             s,
                                            input logic [EXP_W-1:0]  e,
                                            input logic [FRAC_W-1:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/float_divider_if.sv
// ---------------------------------------------------------------------------
// float_divider_if
// Start/valid handshake bundle between the FPU control and the FP32 divider.
//   start      launch request (master -> divider)
//   input_a    dividend, FP32 (master -> divider)
//   input_b    divisor, FP32 (master -> divider)
//   busy       divider not idle (divider -> master)
//   valid      one-cycle result strobe (divider -> master)
//   output_z   quotient, FP32 (divider -> master)
//   exception  error flag qualified by valid (divider -> master)
// Modports: master (requesting side), slave (divider side).
// ---------------------------------------------------------------------------
interface float_divider_if;

  logic        start;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic        busy;
  logic        valid;
  logic [31:0] output_z;
  logic        exception;

  modport master (
    output start, input_a, input_b,
    input  busy, valid, output_z, exception
  );

  modport slave (
    input  start, input_a, input_b,
    output busy, valid, output_z, exception
  );

endinterface

// File: rtl/fdiv_round_pack.sv
// ---------------------------------------------------------------------------
// fdiv_round_pack
// Combinational back end of the FP32 divider: normalises the raw quotient,
// rounds to nearest-even, handles exponent overflow/underflow and packs the
// result word.
// Ports:
//   sign      result sign
//   exp_in    unbiased-difference exponent plus bias, 10-bit signed
//   quo       26-bit raw quotient, MSB first (quo[25] is the integer bit)
//   sticky    1 when the final partial remainder is non-zero
//   result    packed FP32 result
//   overflow  result saturated to infinity (only with FDIV_EXCEPTION_EN)
// Configuration macro: FDIV_EXCEPTION_EN adds the overflow output.
// ---------------------------------------------------------------------------
module fdiv_round_pack
  import fp32_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp_in,
  input  logic [QBITS-1:0]  quo,
  input  logic              sticky,
  output logic [31:0]       result
`ifdef FDIV_EXCEPTION_EN
  , output logic            overflow
`endif
);

  logic [23:0]       mant;
  logic              guard;
  logic              stk;
  logic              round_up;
  logic [24:0]       sum;
  logic [22:0]       frac;
  logic signed [9:0] e_norm;
  logic signed [9:0] e_fin;

  // When the integer bit is set the quotient is already normalised and the
  // lowest quotient bit lies below the guard, so it joins the sticky term.
  // Otherwise shift left one place and lower the exponent. A rounding carry
  // out of the mantissa leaves 1.000..., so the fraction is taken one bit up.
  always_comb begin
    if (quo[25]) begin
      mant   = quo[25:2];
      guard  = quo[1];
      stk    = sticky | quo[0];
      e_norm = exp_in;
    end else begin
      mant   = quo[24:1];
      guard  = quo[0];
      stk    = sticky;
      e_norm = exp_in - 10'sd1;
    end
    round_up = guard & (stk | mant[0]);
    sum      = {1'b0, mant} + {24'd0, round_up};
    frac     = sum[24] ? sum[23:1] : sum[22:0];
    e_fin    = sum[24] ? e_norm + 10'sd1 : e_norm;
    if (e_fin >= 10'sd255) begin
      result = fp32_pack(sign, FP32_INF_EXP, FP32_INF_FRAC);
    end else if (e_fin <= 10'sd0) begin
      result = {sign, 31'd0};
    end else begin
      result = fp32_pack(sign, e_fin[7:0], frac);
    end
  end

`ifdef FDIV_EXCEPTION_EN
  assign overflow = (e_fin >= 10'sd255);
`endif

endmodule

// File: rtl/float_divider.sv
// ---------------------------------------------------------------------------
// float_divider
// Iterative IEEE-754 single-precision divider, z = a / b. Radix-2 restoring
// mantissa division, one quotient bit per cycle, round-to-nearest-even,
// subnormals flushed to signed zero. One operation in flight.
// Ports:
//   clk      clock, rising edge
//   clrn     asynchronous active-low reset
//   enable   global advance; 0 freezes every register
//   bus      float_divider_if.slave: start, input_a, input_b in;
//            busy, valid, output_z, exception out
// Latency from the edge that samples start: valid after 27 more edges for
// normal operands, immediately (same edge) for special operands.
// Configuration macro: FDIV_EXCEPTION_EN enables the registered exception
// flag (invalid, divide-by-zero, overflow); otherwise exception is 0.
// ---------------------------------------------------------------------------
module float_divider
  import fp32_pkg::*;
(
  input  logic           clk,
  input  logic           clrn,
  input  logic           enable,
  float_divider_if.slave bus
);

  fdiv_state_t       state;
  logic [4:0]        count;
  logic [24:0]       rem;
  logic [23:0]       divisor;
  logic [QBITS-1:0]  quo;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [31:0]       z_q;

  fp32_t             op_a;
  fp32_t             op_b;
  logic              res_sign;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              is_invalid;
  logic              is_dz;
  logic              special;
  logic [31:0]       special_z;
  logic              q_bit;
  logic [24:0]       rem_next;
  logic [31:0]       rounded_z;

  assign op_a     = bus.input_a;
  assign op_b     = bus.input_b;
  assign res_sign = op_a.sign[0] ^ op_b.sign[0];

  // Exponent 0 is treated as zero regardless of fraction (subnormal flush).
  assign a_nan  = (op_a.exp == FP32_INF_EXP) && (op_a.frac != '0);
  assign b_nan  = (op_b.exp == FP32_INF_EXP) && (op_b.frac != '0);
  assign a_inf  = (op_a.exp == FP32_INF_EXP) && (op_a.frac == '0);
  assign b_inf  = (op_b.exp == FP32_INF_EXP) && (op_b.frac == '0);
  assign a_zero = (op_a.exp == '0);
  assign b_zero = (op_b.exp == '0);

  // inf/0 is excluded from divide-by-zero: it is an exact infinity.
  assign is_invalid = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
  assign is_dz      = b_zero && !a_inf && !is_invalid;

  // Special-operand results in priority order; anything else goes through
  // the iterative mantissa divider.
  always_comb begin
    special   = 1'b1;
    special_z = '0;
    if (is_invalid) begin
      special_z = FP32_QNAN;
    end else if (is_dz || a_inf) begin
      special_z = fp32_pack(res_sign, FP32_INF_EXP, FP32_INF_FRAC);
    end else if (a_zero || b_inf) begin
      special_z = {res_sign, 31'd0};
    end else begin
      special   = 1'b0;
    end
  end

  // One restoring step: subtract the divisor when it fits, then shift.
  // The remainder stays below twice the divisor, so 25 bits never overflow.
  assign q_bit    = (rem >= {1'b0, divisor});
  assign rem_next = (q_bit ? rem - {1'b0, divisor} : rem) << 1;

`ifdef FDIV_EXCEPTION_EN
  logic exc_q;
  logic round_ovf;

  fdiv_round_pack u_round_pack (
    .sign     (sign_q),
    .exp_in   (exp_q),
    .quo      (quo),
    .sticky   (rem != '0),
    .result   (rounded_z),
    .overflow (round_ovf)
  );
`else
  fdiv_round_pack u_round_pack (
    .sign   (sign_q),
    .exp_in (exp_q),
    .quo    (quo),
    .sticky (rem != '0),
    .result (rounded_z)
  );
`endif

  // Control FSM and datapath registers. enable=0 holds everything, which
  // also makes start invisible while frozen. Results and the flag are
  // loaded together so the flag always describes the current output_z.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      count   <= '0;
      rem     <= '0;
      divisor <= '0;
      quo     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      z_q     <= '0;
`ifdef FDIV_EXCEPTION_EN
      exc_q   <= 1'b0;
`endif
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign_q <= res_sign;
            if (special) begin
              z_q   <= special_z;
`ifdef FDIV_EXCEPTION_EN
              exc_q <= is_invalid || is_dz;
`endif
              state <= DONE;
            end else begin
              rem     <= {2'b01, op_a.frac};
              divisor <= {1'b1, op_b.frac};
              exp_q   <= $signed({2'b00, op_a.exp}) - $signed({2'b00, op_b.exp})
                         + 10'(EXP_BIAS);
              quo     <= '0;
              count   <= 5'(QBITS - 1);
              state   <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          quo <= {quo[QBITS-2:0], q_bit};
          rem <= rem_next;
          if (count == '0) begin
            state <= ROUND;
          end else begin
            count <= count - 5'd1;
          end
        end
        ROUND: begin
          z_q   <= rounded_z;
`ifdef FDIV_EXCEPTION_EN
          exc_q <= round_ovf;
`endif
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.valid    = (state == DONE);
  assign bus.output_z = z_q;
`ifdef FDIV_EXCEPTION_EN
  assign bus.exception = exc_q;
`else
  assign bus.exception = 1'b0;
`endif

endmodule

// File: tb/tb_float_divider.sv
// ---------------------------------------------------------------------------
// tb_float_divider
// Self-checking bench for float_divider: a table of hand-computed divisions
// (result, exception, latency) plus hand-written sequences for stall,
// start-while-busy and reset mid-division. Expected exception values follow
// FDIV_EXCEPTION_EN when the bench is built with it.
// ---------------------------------------------------------------------------
module tb_float_divider;

  logic clk;
  logic clrn;
  logic enable;

  float_divider_if bus_if ();

  float_divider dut (
    .clk    (clk),
    .clrn   (clrn),
    .enable (enable),
    .bus    (bus_if)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic        exc;
    int          lat;
  } vec_t;

  vec_t vecs [17];

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef FDIV_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  // Compares one observed value against the bench's expectation and
  // reports a mismatch on a single line.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Launches one division from IDLE (called #1 after a rising edge) and
  // waits a bounded number of cycles for valid. Optional extras: freeze
  // enable for 5 cycles from cycle stall_at, and pulse start with other
  // operands at cycle busy_start_at. Returns one cycle later, back in IDLE.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                input int stall_at, input int busy_start_at,
                                output logic [31:0] z, output logic exc,
                                output int cycles, output logic busy1);
    logic seen;
    seen  = 1'b0;
    z     = '0;
    exc   = 1'b0;
    busy1 = 1'b0;
    cycles = 0;
    bus_if.input_a = a;
    bus_if.input_b = b;
    bus_if.start   = 1'b1;
    while (!seen && cycles < 80) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) begin
        bus_if.start = 1'b0;
        busy1 = bus_if.busy;
      end
      if (busy_start_at > 0 && cycles == busy_start_at) begin
        bus_if.input_a = 32'h3F80_0000;
        bus_if.input_b = 32'h4040_0000;
        bus_if.start   = 1'b1;
      end
      if (busy_start_at > 0 && cycles == busy_start_at + 1) begin
        bus_if.start = 1'b0;
      end
      if (stall_at > 0 && cycles == stall_at) enable = 1'b0;
      if (stall_at > 0 && cycles == stall_at + 5) enable = 1'b1;
      if (bus_if.valid) begin
        seen = 1'b1;
        z    = bus_if.output_z;
        exc  = bus_if.exception;
      end
    end
    if (seen) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] got_z;
  logic        got_exc;
  logic        got_busy1;
  int          got_cycles;
  logic        saw_valid;

  initial begin
    // Hand-computed vectors: {a, b, z, exception when enabled, latency}.
    vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 28}; // 6/2
    vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 28}; // 1/3 rounds up
    vecs[2]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1};  // 1/0
    vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1, 1};  // 0/0
    vecs[4]  = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b1, 28}; // overflow
    vecs[5]  = '{32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1'b0, 28}; // -6/2
    vecs[6]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 1};  // NaN in
    vecs[7]  = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b1, 1};  // inf/inf
    vecs[8]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1};  // -inf/2
    vecs[9]  = '{32'h0000_0000, 32'hC0A0_0000, 32'h8000_0000, 1'b0, 1};  // 0/-5
    vecs[10] = '{32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 1'b0, 1};  // 1/inf
    vecs[11] = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1};  // subnormal a
    vecs[12] = '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 28}; // underflow
    vecs[13] = '{32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, 1'b0, 28}; // 2/3
    vecs[14] = '{32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1};  // inf/0
    vecs[15] = '{32'hBF80_0000, 32'hBF80_0000, 32'h3F80_0000, 1'b0, 28}; // -1/-1
    vecs[16] = '{32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000, 1'b1, 1};  // 1/subnormal

    // Reset state with clrn held low.
    clrn           = 1'b0;
    enable         = 1'b1;
    bus_if.start   = 1'b0;
    bus_if.input_a = '0;
    bus_if.input_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy",  32'(bus_if.busy),      32'd0);
    check_output("reset_valid", 32'(bus_if.valid),     32'd0);
    check_output("reset_z",     bus_if.output_z,       32'd0);
    check_output("reset_exc",   32'(bus_if.exception), 32'd0);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors, back to back.
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, 0, 0, got_z, got_exc, got_cycles, got_busy1);
      check_output($sformatf("vec%0d_z", i), got_z, vecs[i].z);
      check_output($sformatf("vec%0d_exc", i), 32'(got_exc), 32'(vecs[i].exc & EXC_EN));
      check_output($sformatf("vec%0d_latency", i), 32'(got_cycles), 32'(vecs[i].lat));
      check_output($sformatf("vec%0d_busy", i), 32'(got_busy1), 32'd1);
      check_output($sformatf("vec%0d_strobe", i), 32'(bus_if.valid), 32'd0);
    end

    // Stall mid-DIVIDE for 5 cycles: result arrives 5 cycles later.
    apply_stimulus(32'h40C0_0000, 32'h4000_0000, 5, 0, got_z, got_exc, got_cycles, got_busy1);
    check_output("stall_z", got_z, 32'h4040_0000);
    check_output("stall_latency", 32'(got_cycles), 32'd33);

    // Start while busy is ignored: the 6/2 result stands, nothing follows.
    apply_stimulus(32'h40C0_0000, 32'h4000_0000, 0, 3, got_z, got_exc, got_cycles, got_busy1);
    check_output("busy_start_z", got_z, 32'h4040_0000);
    check_output("busy_start_latency", 32'(got_cycles), 32'd28);
    repeat (3) @(posedge clk);
    #1;
    check_output("busy_start_no_relaunch", 32'(bus_if.busy), 32'd0);
    check_output("busy_start_z_held", bus_if.output_z, 32'h4040_0000);

    // Reset mid-DIVIDE: everything clears at once and no result appears.
    bus_if.input_a = 32'h40C0_0000;
    bus_if.input_b = 32'h4000_0000;
    bus_if.start   = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    clrn = 1'b0;
    #1;
    check_output("abort_busy",  32'(bus_if.busy),  32'd0);
    check_output("abort_valid", 32'(bus_if.valid), 32'd0);
    check_output("abort_z",     bus_if.output_z,   32'd0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus_if.valid) saw_valid = 1'b1;
    end
    check_output("abort_no_valid", 32'(saw_valid), 32'd0);

    // The divider still works after the abort.
    apply_stimulus(32'h4000_0000, 32'h4040_0000, 0, 0, got_z, got_exc, got_cycles, got_busy1);
    check_output("recover_z", got_z, 32'h3F2A_AAAB);
    check_output("recover_latency", 32'(got_cycles), 32'd28);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
